// File: rtl/control_unit_ws.sv
// control_unit_ws: multi-phase CPU control sequencer with memory wait states, LDI16 and HLT.
// Ports: clk/rst (sync, active-low); ir, flags, resume in; mem_oe/mem_we, d_to_di_oe, ir_we,
// we_a/we_b/we_pl/we_ph, oe_*_alu, oe_a_d/oe_b_d, we_flags, alu_oe out (active-low);
// ip_inc, addr_dp, swap_p, halted out (active-high); alu_op out = ir[6:3].
module control_unit_ws #(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned WAIT_W      = 4,
  parameter bit          LDI16_EN    = 1'b1,
  parameter bit          HALT_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ir,
  input  logic [3:0] flags,
  input  logic       resume,
  output logic       mem_oe,
  output logic       mem_we,
  output logic       d_to_di_oe,
  output logic       ir_we,
  output logic       ip_inc,
  output logic       addr_dp,
  output logic       swap_p,
  output logic       we_a,
  output logic       we_b,
  output logic       we_pl,
  output logic       we_ph,
  output logic       oe_b_alu,
  output logic       oe_pl_alu,
  output logic       oe_ph_alu,
  output logic       oe_a_d,
  output logic       oe_b_d,
  output logic       we_flags,
  output logic [3:0] alu_op,
  output logic       alu_oe,
  output logic       halted
);
  typedef enum logic [2:0] {FETCH, EXEC, MEM, IMM, IMM_H, HALT} state_e;
  state_e state_q, state_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic commit, mem_ph;
  logic is_alu, is_ld, is_st, is_ldi, is_l16, is_jc, is_jmp, is_hlt;
  logic [3:0] sel, wr;
  logic [3:1] oa;
  logic rd, wm, di, irl, inc, adp, swp, a_d, b_d, fl, aoe, hlt;
  // last clock of a memory phase: the only clock that may latch registers or bump IP
  assign commit = wcnt_q == WAIT_W'(WAIT_STATES);
  assign mem_ph = state_q inside {FETCH, MEM, IMM, IMM_H};
  // one-hot register select from dd: bit0=A, bit1=B, bit2=PL, bit3=PH
  assign sel    = 4'b0001 << ir[1:0];
  assign is_alu = !ir[7];
  assign is_ld  = ir[7:4] == 4'b1000;
  assign is_st  = ir[7:4] == 4'b1001;
  assign is_ldi = ir[7:4] == 4'b1010;
  assign is_l16 = LDI16_EN && ir[7:4] == 4'b1011;
  assign is_jc  = ir[7:3] == 5'b11000;
  assign is_jmp = ir[7:3] == 5'b11001;
  assign is_hlt = HALT_EN && ir[7:4] == 4'b1111;
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:      state_d = commit ? EXEC : FETCH;
      EXEC:       state_d = (is_ld || is_st) ? MEM : (is_ldi || is_l16) ? IMM : is_hlt ? HALT : FETCH;
      MEM, IMM_H: state_d = commit ? FETCH : state_q;
      IMM:        state_d = commit ? (is_l16 ? IMM_H : FETCH) : IMM;
      HALT:       state_d = resume ? FETCH : HALT;
      default:    state_d = FETCH;
    endcase
    wcnt_d = (state_d != state_q || !mem_ph) ? '0 : wcnt_q + WAIT_W'(1);
  end
  always_comb begin
    rd  = 1'b0;
    wm  = 1'b0;
    di  = 1'b0;
    irl = 1'b0;
    inc = 1'b0;
    adp = 1'b0;
    swp = 1'b0;
    a_d = 1'b0;
    b_d = 1'b0;
    fl  = 1'b0;
    aoe = 1'b0;
    hlt = 1'b0;
    wr  = '0;
    oa  = '0;
    case (state_q)
      FETCH: begin
        rd  = 1'b1;
        irl = commit;
        inc = commit;
      end
      EXEC: begin
        aoe = is_alu;
        fl  = is_alu;
        oa  = is_alu ? sel[3:1] : '0;
        wr  = is_alu ? (ir[2] ? sel : 4'b0001) : '0;
        swp = (is_jc && (flags[ir[1:0]] ^ ir[2])) || is_jmp;
      end
      MEM: begin
        adp = 1'b1;
        rd  = is_ld;
        di  = is_ld;
        wr  = (is_ld && commit) ? sel : '0;
        wm  = is_st;
        a_d = is_st && !ir[0];
        b_d = is_st && ir[0];
      end
      IMM: begin
        rd  = 1'b1;
        di  = 1'b1;
        inc = commit;
        wr  = commit ? (is_l16 ? 4'b0100 : sel) : '0;
      end
      IMM_H: begin
        rd  = 1'b1;
        di  = 1'b1;
        inc = commit;
        wr  = commit ? 4'b1000 : '0;
      end
      HALT:    hlt = 1'b1;
      default: hlt = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FETCH;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end
  // every strobe is forced inactive while reset is held, so an aborted phase never commits
  assign mem_oe     = !(rst && rd);
  assign mem_we     = !(rst && wm);
  assign d_to_di_oe = !(rst && di);
  assign ir_we      = !(rst && irl);
  assign ip_inc     = rst && inc;
  assign addr_dp    = rst && adp;
  assign swap_p     = rst && swp;
  assign we_a       = !(rst && wr[0]);
  assign we_b       = !(rst && wr[1]);
  assign we_pl      = !(rst && wr[2]);
  assign we_ph      = !(rst && wr[3]);
  assign oe_b_alu   = !(rst && oa[1]);
  assign oe_pl_alu  = !(rst && oa[2]);
  assign oe_ph_alu  = !(rst && oa[3]);
  assign oe_a_d     = !(rst && a_d);
  assign oe_b_d     = !(rst && b_d);
  assign we_flags   = !(rst && fl);
  assign alu_oe     = !(rst && aoe);
  assign halted     = rst && hlt;
  assign alu_op     = ir[6:3];
endmodule
